// File: rtl/polyvecz_pack_ctrl_pkg.sv
// Shared Dilithium constants, the z-pack FSM state type and per-coefficient
// encode / range helpers for the gamma1 = 2^19 response format.
package polyvecz_pack_ctrl_pkg;

   localparam int N                 = 256;
   localparam int GAMMA1_LOG        = 19;
   localparam int GAMMA1            = 1 << GAMMA1_LOG;
   localparam int POLYZ_PACKEDBYTES = 640;
   localparam int PAIRS_PER_POLY    = N / 2;
   localparam int COEF_W            = GAMMA1_LOG + 1;
   localparam int WORD_W            = 2 * COEF_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } pack_state_e;

   // gamma1 - a taken mod 2^32; only the low 20 bits go on the wire
   function automatic logic [COEF_W-1:0] z_encode(input logic signed [31:0] a);
      logic [31:0] diff;
      diff = 32'(GAMMA1) - a;
      return diff[COEF_W-1:0];
   endfunction

   function automatic logic z_in_range(input logic signed [31:0] a);
      return (a > -GAMMA1) && (a <= GAMMA1);
   endfunction

endpackage

// File: rtl/polyvecz_pack_ctrl_pair_pack.sv
// Combinational packer for one coefficient pair {a1, a0} into a 40-bit
// little-endian word {t1, t0}, with an out-of-range flag for either coefficient.
module polyz_pair_pack
   import polyvecz_pack_ctrl_pkg::*;
(
   input  logic [63:0]       pair_data,
   output logic [WORD_W-1:0] word,
   output logic              range_err
);

   logic signed [31:0] a0;
   logic signed [31:0] a1;

   assign a0        = pair_data[31:0];
   assign a1        = pair_data[63:32];
   assign word      = {z_encode(a1), z_encode(a0)};
   assign range_err = !(z_in_range(a0) && z_in_range(a1));

endmodule

// File: rtl/polyvecz_pack_ctrl.sv
// Sequencer that streams the z vector out of the coefficient RAM, packs each
// pair and hands 40-bit words to the signature writer through a 2-entry FIFO.
module polyvecz_pack_ctrl
   import polyvecz_pack_ctrl_pkg::*;
#(
   parameter int L      = 5,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              range_err,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [63:0]       rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_idx
);

   localparam int PW     = (L > 1) ? $clog2(L) : 1;
   localparam int PAIR_W = $clog2(PAIRS_PER_POLY);

   pack_state_e       state_q, state_d;
   logic [PAIR_W-1:0] pair_q, pair_d;
   logic [PW-1:0]     poly_q, poly_d;
   logic              rdv_q, rdv_d;
   logic [1:0]        count_q, count_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              range_err_q, range_err_d;
   logic [ADDR_W-1:0] out_idx_q, out_idx_d;
   logic [WORD_W-1:0] mem_q [2];

   logic              pop;
   logic              push;
   logic              issue;
   logic              last_pair;
   logic [2:0]        occupancy;
   logic [WORD_W-1:0] pack_word;
   logic              pack_err;

   polyz_pair_pack u_pair_pack (
      .pair_data (rd_data),
      .word      (pack_word),
      .range_err (pack_err)
   );

   // rdv_q marks the cycle in which rd_data carries the pair read last cycle
   assign push      = rdv_q;
   assign pop       = out_valid && out_ready;
   assign occupancy = {1'b0, count_q} + {2'b00, rdv_q} - {2'b00, pop};
   assign issue     = (state_q == RUN) && (occupancy < 3'd2);
   assign last_pair = (poly_q == PW'(L - 1)) && (pair_q == PAIR_W'(PAIRS_PER_POLY - 1));

   always_comb begin
      state_d     = state_q;
      pair_d      = pair_q;
      poly_d      = poly_q;
      rdv_d       = issue;
      count_d     = count_q + {1'b0, push} - {1'b0, pop};
      wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d    = pop ? ~rd_ptr_q : rd_ptr_q;
      range_err_d = range_err_q | (push & pack_err);
      out_idx_d   = pop ? out_idx_q + ADDR_W'(1) : out_idx_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = RUN;
               pair_d      = '0;
               poly_d      = '0;
               range_err_d = 1'b0;
               out_idx_d   = '0;
            end
         end
         RUN: begin
            if (issue) begin
               if (last_pair) begin
                  state_d = DRAIN;
               end else if (pair_q == PAIR_W'(PAIRS_PER_POLY - 1)) begin
                  pair_d = '0;
                  poly_d = poly_q + PW'(1);
               end else begin
                  pair_d = pair_q + PAIR_W'(1);
               end
            end
         end
         DRAIN: begin
            if (!rdv_q && (count_d == 2'd0)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pair_q      <= '0;
         poly_q      <= '0;
         rdv_q       <= 1'b0;
         count_q     <= 2'd0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         range_err_q <= 1'b0;
         out_idx_q   <= '0;
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         pair_q      <= pair_d;
         poly_q      <= poly_d;
         rdv_q       <= rdv_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         range_err_q <= range_err_d;
         out_idx_q   <= out_idx_d;
         if (push) begin
            mem_q[wr_ptr_q] <= pack_word;
         end
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign range_err = range_err_q;
   assign rd_en     = issue;
   assign rd_addr   = ADDR_W'({poly_q, pair_q});
   assign out_valid = (count_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];
   assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_polyvecz_pack_ctrl.sv
// Scoreboard bench for polyvecz_pack_ctrl: expected words come from a byte-level
// model of the packed signature; a monitor pops and compares on each handshake.
module tb_polyvecz_pack_ctrl;

   localparam int L      = 5;
   localparam int ADDR_W = 10;
   localparam int NW     = L * 128;
   localparam int NC     = 2 * NW;
   localparam int BUDGET = 20000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              busy;
   logic              done;
   logic              range_err;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [63:0]       rd_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [39:0]       out_data;
   logic [ADDR_W-1:0] out_idx;

   polyvecz_pack_ctrl #(.L(L), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .range_err (range_err),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [39:0] data;
      int          idx;
   } exp_t;

   exp_t       exp_q[$];
   int         zmem [NC];
   logic [7:0] sig  [5*NW];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         hs_count = 0;
   int         done_count = 0;
   int         max_out = 0;
   int         first_bad = NW + 2;
   int         ready_mode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [19:0] ref_t(input int a);
      longint     d;
      logic [63:0] dv;
      d  = longint'(524288) - longint'(a);
      dv = 64'(d);
      return dv[19:0];
   endfunction

   function automatic bit ref_bad(input int a);
      return !((a > -524288) && (a <= 524288));
   endfunction

   // Bit-serialise every coefficient LSB-first into the signature byte
   // stream, then cut it into 5-byte words.
   task automatic build_expected();
      logic [19:0] t;
      int          pos;
      for (int i = 0; i < 5*NW; i++) sig[i] = 8'h00;
      first_bad = NW + 2;
      for (int c = 0; c < NC; c++) begin
         t = ref_t(zmem[c]);
         for (int b = 0; b < 20; b++) begin
            pos = 20*c + b;
            sig[pos/8][pos%8] = t[b];
         end
         if (ref_bad(zmem[c]) && (c/2 < first_bad)) first_bad = c/2;
      end
      for (int k = 0; k < NW; k++) begin
         exp_q.push_back('{data: {sig[5*k+4], sig[5*k+3], sig[5*k+2], sig[5*k+1], sig[5*k]},
                           idx: k});
      end
   endtask

   task automatic fill(input int kind);
      int r;
      for (int c = 0; c < NC; c++) begin
         r = int'($urandom_range(0, 1048575));
         case (kind)
            0: zmem[c] = 0;
            1: zmem[c] = r - 524287;
            default: begin
               zmem[c] = r - 524287;
               if ($urandom_range(0, 199) == 0) begin
                  case ($urandom_range(0, 2))
                     0: zmem[c] = 524289;
                     1: zmem[c] = -524288;
                     default: zmem[c] = int'($urandom()) | 32'h4000_0000;
                  endcase
               end
            end
         endcase
      end
   endtask

   // Coefficient RAM: one-cycle registered read, garbage when not read.
   initial begin
      forever begin
         @(posedge clk);
         if (rd_en) rd_data <= {zmem[2*rd_addr+1], zmem[2*rd_addr]};
         else       rd_data <= {$urandom(), $urandom()};
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 9) < 6);
            default: out_ready = ~out_ready;
         endcase
      end
   end

   // Monitor: handshakes, stall stability, outstanding reads, range flag.
   initial begin
      exp_t        e;
      logic        prev_stall = 1'b0;
      logic [39:0] prev_data  = '0;
      logic [ADDR_W-1:0] prev_idx = '0;
      int          issued = 0;
      int          popped = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
            issued     = 0;
            popped     = 0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", out_valid, 1);
               check("stall_data", out_data, prev_data);
               check("stall_idx", out_idx, prev_idx);
            end
            if (done) done_count++;
            if (rd_en) issued++;
            if (out_valid && out_ready) begin
               popped++;
               hs_count++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_word: actual idx %0d data %0h required none", out_idx, out_data);
               end else begin
                  e = exp_q.pop_front();
                  check("word_data", out_data, e.data);
                  check("word_idx", out_idx, e.idx);
                  if (first_bad <= e.idx)         check("range_err_set", range_err, 1);
                  else if (first_bad > e.idx + 1) check("range_err_clear", range_err, 0);
               end
            end
            if (issued - popped > max_out) max_out = issued - popped;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_pack(input int mode, input bit restart_mid, input bit chk_cycle);
      int base_hs, base_done, done_cyc;
      ready_mode = mode;
      build_expected();
      base_hs   = hs_count;
      base_done = done_count;
      max_out   = 0;
      done_cyc  = -1;
      pulse_start();
      for (int k = 1; k <= BUDGET; k++) begin
         @(negedge clk);
         #1;
         if (k == 1) begin
            check("c1_busy", busy, 1);
            check("c1_rd_en", rd_en, 1);
            check("c1_rd_addr", rd_addr, 0);
            check("c1_range_err", range_err, 0);
         end
         if (k == 2) check("c2_out_valid", out_valid, 0);
         if (k == 3) check("c3_out_valid", out_valid, 1);
         if (restart_mid && k == 100) start = 1'b1;
         if (restart_mid && k == 101) start = 1'b0;
         if (done) begin
            done_cyc = k;
            check("done_busy", busy, 1);
            break;
         end
      end
      start = 1'b0;
      if (done_cyc < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: actual none required done within %0d cycles", BUDGET);
      end
      if (chk_cycle) check("done_cycle", done_cyc, 643);
      check("word_count", hs_count - base_hs, NW);
      check("queue_empty", exp_q.size(), 0);
      @(negedge clk);
      #1;
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      repeat (3) @(negedge clk);
      #1;
      check("done_pulses", done_count - base_done, 1);
      check("outstanding_le2", (max_out <= 2), 1);
      exp_q.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_range_err"}, range_err, 0);
      check({tag, "_rd_en"}, rd_en, 0);
      check({tag, "_rd_addr"}, rd_addr, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_out_idx"}, out_idx, 0);
   endtask

   initial begin
      int base_hs, seen_done;
      bool_dummy: begin end
      repeat (3) @(negedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // All-zero vector, sink always ready: exact latency and done cycle.
      fill(0);
      run_pack(0, 1'b0, 1'b1);
      check("zero_range_err", range_err, 0);

      // Encodable extremes in pair 0.
      fill(1);
      zmem[0] = 524288;
      zmem[1] = -524287;
      run_pack(0, 1'b0, 1'b1);
      check("edge_range_err", range_err, 0);

      // -2^19 at pair 37 with random stalls; flag stays set while idle.
      fill(1);
      zmem[74] = -524288;
      run_pack(1, 1'b0, 1'b0);
      check("p37_range_err", range_err, 1);
      repeat (4) @(negedge clk);
      #1;
      check("sticky_range_err", range_err, 1);

      // Random data with sporadic bad coefficients, toggling ready, start re-pulsed mid-run.
      fill(2);
      run_pack(2, 1'b1, 1'b0);

      // Reset at word 300.
      fill(1);
      ready_mode = 1;
      build_expected();
      base_hs = hs_count;
      pulse_start();
      for (int k = 0; k < BUDGET; k++) begin
         @(negedge clk);
         #1;
         if (hs_count - base_hs >= 300) break;
      end
      check("reached_300", (hs_count - base_hs >= 300), 1);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      repeat (6) begin
         @(negedge clk);
         #1;
         if (done || busy) seen_done++;
      end
      check("no_done_after_reset", seen_done, 0);

      // Fresh run after reset restarts at word 0.
      fill(2);
      run_pack(1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
